ddio_out_burst: RTL

Parametrised multi-bit DDR output block with an internal burst FIFO and output-enable sequencing. It accepts (high, low) word pairs over a valid/ready handshake, buffers them, and drives them onto a WIDTH-bit pad bus at double data rate: the high word while clk is high, the low word while clk is low. It generates padoe for each burst, with an optional one-cycle OE-disable extension, and flags underruns. It sits between the core-side transmit logic and the I/O pads.

---
 rtl/ddio_out_burst.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ddio_out_burst.sv
// DDR pad output stage with a small burst FIFO, output-enable sequencing
// and underrun detection. The high word drives the pad while clk is high.
module ddio_out_burst #(
  parameter int    WIDTH              = 8,
  parameter int    DEPTH              = 4,
  parameter string OUTPUT_ASYNC_RESET = "clear",
  parameter string EXTEND_OE_DISABLE  = "false"
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     clkena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [WIDTH-1:0]         datain_h,
  input  logic [WIDTH-1:0]         datain_l,
  output logic [WIDTH-1:0]         padout,
  output logic                     padoe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] IDLE_VAL = (OUTPUT_ASYNC_RESET == "preset") ? '1 : '0;
  localparam bit               EXTEND   = (EXTEND_OE_DISABLE == "true");

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [WIDTH-1:0] mem_h_q [DEPTH];
  logic [WIDTH-1:0] mem_l_q [DEPTH];
  logic             mem_last_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] reg_h_q, reg_h_d, reg_l_q, reg_l_d;
  logic             padoe_q, padoe_d, underrun_q, underrun_d;
  logic             wr_en, rd_en, empty;

  // in_ready is held low for the whole reset window, not just after it.
  assign in_ready   = !areset && (level_q != FULL_LVL);
  assign wr_en      = in_valid && in_ready;
  assign empty      = (level_q == '0);
  assign padout     = clk ? reg_h_q : reg_l_q;
  assign padoe      = padoe_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_h_q[wr_ptr_q]    <= datain_h;
      mem_l_q[wr_ptr_q]    <= datain_l;
      mem_last_q[wr_ptr_q] <= in_last;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_h_d    = reg_h_q;
    reg_l_d    = reg_l_q;
    padoe_d    = padoe_q;
    underrun_d = 1'b0;
    rd_en      = 1'b0;
    if (clkena) begin
      case (state_q)
        ST_IDLE, ST_BURST: begin
          if (!empty) begin
            rd_en   = 1'b1;
            reg_h_d = mem_h_q[rd_ptr_q];
            reg_l_d = mem_l_q[rd_ptr_q];
            padoe_d = 1'b1;
            if (mem_last_q[rd_ptr_q]) state_d = EXTEND ? ST_TAIL : ST_DONE;
            else                      state_d = ST_BURST;
          end else if (state_q == ST_BURST) begin
            underrun_d = 1'b1;
            reg_h_d    = IDLE_VAL;
            reg_l_d    = IDLE_VAL;
          end
        end
        ST_TAIL: begin
          reg_h_d = IDLE_VAL;
          reg_l_d = IDLE_VAL;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          padoe_d = 1'b0;
          reg_h_d = IDLE_VAL;
          reg_l_d = IDLE_VAL;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    level_d  = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= ST_IDLE;
      reg_h_q    <= IDLE_VAL;
      reg_l_q    <= IDLE_VAL;
      padoe_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      reg_h_q    <= reg_h_d;
      reg_l_q    <= reg_l_d;
      padoe_q    <= padoe_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
